// File: rtl/cpu_pkg.sv
// Shared encodings and pipeline bundles
// for the five-stage MIPS-subset core.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctl_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    logic     mem_write;
    logic     branch;
    logic     alu_src;
    logic     reg_dst;
    alu_ctl_e alu_ctl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_ctl:    ALU_ADD
  };

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        zero;
    logic [31:0] target;
    logic [31:0] alu;
    logic [31:0] rt_val;
    logic [4:0]  dst;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu;
    logic [31:0] load;
    logic [4:0]  dst;
  } mem_wb_t;

endpackage

// File: rtl/ALU.sv
// 32-bit wrap-around ALU with
// zero flag for beq.
module ALU import cpu_pkg::*; (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_ctl_e    ctl_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  // operation select
  always_comb begin
    y_o = '0;
    unique case (ctl_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == 32'd0);

endmodule

// File: rtl/Control.sv
// Main and ALU decode; anything not
// recognised becomes a nop.
module Control import cpu_pkg::*; (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);

  logic     fn_ok;
  alu_ctl_e fn_ctl;

  // R-type function decode
  always_comb begin
    fn_ok  = 1'b1;
    fn_ctl = ALU_ADD;
    unique case (1'b1)
      funct_i == FN_ADD: fn_ctl = ALU_ADD;
      funct_i == FN_SUB: fn_ctl = ALU_SUB;
      funct_i == FN_AND: fn_ctl = ALU_AND;
      funct_i == FN_OR:  fn_ctl = ALU_OR;
      funct_i == FN_SLT: fn_ctl = ALU_SLT;
      default:           fn_ok  = 1'b0;
    endcase
  end

  // opcode decode
  always_comb begin
    ctrl_o = CTRL_NOP;
    unique case (1'b1)
      op_i == OP_RTYPE: begin
        ctrl_o.reg_write = fn_ok;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_ctl   = fn_ctl;
      end
      op_i == OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = 1'b1;
      end
      op_i == OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      op_i == OP_BEQ: begin
        ctrl_o.branch  = 1'b1;
        ctrl_o.alu_ctl = ALU_SUB;
      end
      op_i == OP_ADDI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      default: ctrl_o = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/DataMemory.sv
// Word-addressed data store with
// combinational read, clocked write.
module DataMemory #(
  parameter int SIZE = 32
) (
  input  logic        clock,
  input  logic        we_i,
  input  logic [29:0] addr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [31:0]   data [0:SIZE-1];
  logic [AW-1:0] idx;

  assign idx  = AW'(addr_i % 30'(SIZE));
  assign rd_o = data[idx];

  // store word
  always_ff @(posedge clock) begin
    if (we_i) data[idx] <= wd_i;
  end

endmodule

// File: rtl/InstructionMemory.sv
// Word-addressed program store; the
// write port is only a preload hook.
module InstructionMemory #(
  parameter int SIZE = 32
) (
  input  logic        clock,
  input  logic        we_i,
  input  logic [29:0] wa_i,
  input  logic [31:0] wd_i,
  input  logic [29:0] addr_i,
  output logic [31:0] rd_o
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [31:0]   data [0:SIZE-1];
  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;

  assign ridx = AW'(addr_i % 30'(SIZE));
  assign widx = AW'(wa_i % 30'(SIZE));
  assign rd_o = data[ridx];

  // optional program load
  always_ff @(posedge clock) begin
    if (we_i) data[widx] <= wd_i;
  end

endmodule

// File: rtl/ProgramCounter.sv
// Fetch address register: steps by 4
// or loads a resolved branch target.
module ProgramCounter (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc;
  logic [31:0] pc_d;

  // next fetch address
  always_comb begin
    pc_d = pc + 32'd4;
    if (load_i) pc_d = target_i;
  end

  // pc register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) pc <= '0;
    else       pc <= pc_d;
  end

  assign pc_o = pc;

endmodule

// File: rtl/Registers.sv
// 32x32 register file, $0 hardwired,
// write data bypassed to readers.
module Registers (
  input  logic        clock,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rda_o,
  output logic [31:0] rdb_o
);

  logic [31:0] data [0:31];
  logic        wr;

  assign wr = we_i && (wa_i != 5'd0);

  // read ports with same-cycle bypass
  always_comb begin
    rda_o = data[ra_i];
    rdb_o = data[rb_i];
    if (wr && wa_i == ra_i) rda_o = wd_i;
    if (wr && wa_i == rb_i) rdb_o = wd_i;
    if (ra_i == 5'd0) rda_o = '0;
    if (rb_i == 5'd0) rdb_o = '0;
  end

  // write port
  always_ff @(posedge clock) begin
    if (wr) data[wa_i] <= wd_i;
  end

endmodule

// File: rtl/cpu.sv
// Five-stage pipeline top: no hazard
// logic, three branch delay slots.
module cpu import cpu_pkg::*; #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_MEM_SIZE  = 32
) (
  input logic clock,
  input logic reset
);

  if_id_t  if_id_q,  if_id_d;
  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic [31:0] pc, instr;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_b, alu_y;
  logic [31:0] load_data, wb_data;
  logic        alu_zero, taken;
  ctrl_t       ctrl;

  assign taken   = ex_mem_q.branch & ex_mem_q.zero;
  assign wb_data = mem_wb_q.mem_to_reg ? mem_wb_q.load
                                       : mem_wb_q.alu;
  assign alu_b   = id_ex_q.ctrl.alu_src ? id_ex_q.imm
                                        : id_ex_q.rt_val;

  ProgramCounter ProgramCounter_0 (
    .clock    (clock),
    .reset    (reset),
    .load_i   (taken),
    .target_i (ex_mem_q.target),
    .pc_o     (pc)
  );

  InstructionMemory #(.SIZE(INSTR_MEM_SIZE)) InstructionMemory_0 (
    .clock  (clock),
    .we_i   (1'b0),
    .wa_i   (30'd0),
    .wd_i   (NOP_WORD),
    .addr_i (pc[31:2]),
    .rd_o   (instr)
  );

  Registers Registers_0 (
    .clock (clock),
    .ra_i  (if_id_q.instr[25:21]),
    .rb_i  (if_id_q.instr[20:16]),
    .we_i  (mem_wb_q.reg_write & ~reset),
    .wa_i  (mem_wb_q.dst),
    .wd_i  (wb_data),
    .rda_o (rs_val),
    .rdb_o (rt_val)
  );

  Control Control_0 (
    .op_i    (if_id_q.instr[31:26]),
    .funct_i (if_id_q.instr[5:0]),
    .ctrl_o  (ctrl)
  );

  ALU ALU_0 (
    .a_i    (id_ex_q.rs_val),
    .b_i    (alu_b),
    .ctl_i  (id_ex_q.ctrl.alu_ctl),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  DataMemory #(.SIZE(DATA_MEM_SIZE)) DataMemory_0 (
    .clock  (clock),
    .we_i   (ex_mem_q.mem_write & ~reset),
    .addr_i (ex_mem_q.alu[31:2]),
    .wd_i   (ex_mem_q.rt_val),
    .rd_o   (load_data)
  );

  // next contents of every pipeline register
  always_comb begin
    if_id_d.pc4   = pc + 32'd4;
    if_id_d.instr = instr;

    id_ex_d.ctrl   = ctrl;
    id_ex_d.pc4    = if_id_q.pc4;
    id_ex_d.rs_val = rs_val;
    id_ex_d.rt_val = rt_val;
    id_ex_d.imm    = {{16{if_id_q.instr[15]}},
                      if_id_q.instr[15:0]};
    id_ex_d.rt     = if_id_q.instr[20:16];
    id_ex_d.rd     = if_id_q.instr[15:11];

    ex_mem_d.reg_write  = id_ex_q.ctrl.reg_write;
    ex_mem_d.mem_to_reg = id_ex_q.ctrl.mem_to_reg;
    ex_mem_d.mem_write  = id_ex_q.ctrl.mem_write;
    ex_mem_d.branch     = id_ex_q.ctrl.branch;
    ex_mem_d.zero       = alu_zero;
    ex_mem_d.target     = id_ex_q.pc4 + (id_ex_q.imm << 2);
    ex_mem_d.alu        = alu_y;
    ex_mem_d.rt_val     = id_ex_q.rt_val;
    ex_mem_d.dst        = id_ex_q.ctrl.reg_dst ? id_ex_q.rd
                                               : id_ex_q.rt;

    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
    mem_wb_d.alu        = ex_mem_q.alu;
    mem_wb_d.load       = load_data;
    mem_wb_d.dst        = ex_mem_q.dst;
  end

  // pipeline registers; reset flushes to nop
  always_ff @(posedge clock) begin
    if (reset) begin
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed-program checks for the
// pipelined cpu top.
module tb_cpu;

  logic clock;
  logic reset;
  int   checks;
  int   fails;

  cpu #(.INSTR_MEM_SIZE(32), .DATA_MEM_SIZE(32)) dut (
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_op(
    int rd, int rs, int rt, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(
    int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic boot();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      dut.InstructionMemory_0.data[i] = 32'h0;
      dut.DataMemory_0.data[i] = 32'hD000_0000 | 32'(i);
      dut.Registers_0.data[i] = 32'(i);
    end
  endtask

  task automatic go();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    boot();
    dut.InstructionMemory_0.data[0] = i_op(8, 0, 16, 99);
    dut.InstructionMemory_0.data[1] = i_op(43, 0, 1, 0);
    go();
    tick(2);
    checks++;
    if (dut.ProgramCounter_0.pc !== 32'd8) begin
      fails++;
      $display("FAIL rst_pre_pc got %h want %h",
               dut.ProgramCounter_0.pc, 32'd8);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dut.ProgramCounter_0.pc !== 32'd0) begin
        fails++;
        $display("FAIL rst_pc%0d got %h want %h", k,
                 dut.ProgramCounter_0.pc, 32'd0);
      end
    end
    tick(3);
    checks++;
    if (dut.Registers_0.data[16] !== 32'd16) begin
      fails++;
      $display("FAIL rst_r16 got %h want %h",
               dut.Registers_0.data[16], 32'd16);
    end
    checks++;
    if (dut.DataMemory_0.data[0] !== 32'hD000_0000) begin
      fails++;
      $display("FAIL rst_mem0 got %h want %h",
               dut.DataMemory_0.data[0], 32'hD000_0000);
    end
  endtask

  task automatic test_program();
    boot();
    dut.InstructionMemory_0.data[0] = r_op(18, 4, 8, 'h20);
    dut.InstructionMemory_0.data[1] = r_op(9, 1, 2, 'h2A);
    dut.InstructionMemory_0.data[3] = i_op(43, 0, 18, 64);
    go();
    tick(8);
    checks++;
    if (dut.Registers_0.data[18] !== 32'd12) begin
      fails++;
      $display("FAIL prog_r18 got %h want %h",
               dut.Registers_0.data[18], 32'd12);
    end
    checks++;
    if (dut.Registers_0.data[9] !== 32'd1) begin
      fails++;
      $display("FAIL prog_r9 got %h want %h",
               dut.Registers_0.data[9], 32'd1);
    end
    checks++;
    if (dut.DataMemory_0.data[16] !== 32'd12) begin
      fails++;
      $display("FAIL prog_mem16 got %h want %h",
               dut.DataMemory_0.data[16], 32'd12);
    end
    checks++;
    if (dut.ProgramCounter_0.pc !== 32'd32) begin
      fails++;
      $display("FAIL prog_pc got %h want %h",
               dut.ProgramCounter_0.pc, 32'd32);
    end
    for (int i = 0; i < 32; i++) begin
      if (i != 18 && i != 9) begin
        checks++;
        if (dut.Registers_0.data[i] !== 32'(i)) begin
          fails++;
          $display("FAIL prog_keep_r%0d got %h want %h", i,
                   dut.Registers_0.data[i], 32'(i));
        end
      end
    end
  endtask

  task automatic test_load();
    boot();
    dut.DataMemory_0.data[2] = 32'h1234;
    dut.InstructionMemory_0.data[0] = i_op('h23, 0, 10, 8);
    dut.InstructionMemory_0.data[1] = i_op(8, 0, 11, -1);
    go();
    tick(4);
    checks++;
    if (dut.Registers_0.data[10] !== 32'd10) begin
      fails++;
      $display("FAIL lw_early got %h want %h",
               dut.Registers_0.data[10], 32'd10);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[10] !== 32'h1234) begin
      fails++;
      $display("FAIL lw_r10 got %h want %h",
               dut.Registers_0.data[10], 32'h1234);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[11] !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL addi_r11 got %h want %h",
               dut.Registers_0.data[11], 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_alu();
    boot();
    dut.Registers_0.data[28] = 32'hFFFF_FFF0;
    dut.InstructionMemory_0.data[0] = r_op(12, 3, 5, 'h22);
    dut.InstructionMemory_0.data[1] = r_op(13, 6, 3, 'h24);
    dut.InstructionMemory_0.data[2] = r_op(14, 4, 1, 'h25);
    dut.InstructionMemory_0.data[3] = r_op(15, 28, 1, 'h2A);
    go();
    tick(8);
    checks++;
    if (dut.Registers_0.data[12] !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL sub_r12 got %h want %h",
               dut.Registers_0.data[12], 32'hFFFF_FFFE);
    end
    checks++;
    if (dut.Registers_0.data[13] !== 32'd2) begin
      fails++;
      $display("FAIL and_r13 got %h want %h",
               dut.Registers_0.data[13], 32'd2);
    end
    checks++;
    if (dut.Registers_0.data[14] !== 32'd5) begin
      fails++;
      $display("FAIL or_r14 got %h want %h",
               dut.Registers_0.data[14], 32'd5);
    end
    checks++;
    if (dut.Registers_0.data[15] !== 32'd1) begin
      fails++;
      $display("FAIL slt_signed got %h want %h",
               dut.Registers_0.data[15], 32'd1);
    end
  endtask

  task automatic test_branch();
    boot();
    dut.InstructionMemory_0.data[0] = i_op(4, 1, 1, 4);
    dut.InstructionMemory_0.data[1] = i_op(8, 0, 23, 7);
    dut.InstructionMemory_0.data[2] = i_op(8, 0, 24, 8);
    dut.InstructionMemory_0.data[3] = i_op(8, 0, 25, 9);
    dut.InstructionMemory_0.data[4] = i_op(8, 0, 26, 5);
    dut.InstructionMemory_0.data[5] = i_op(8, 0, 27, 6);
    go();
    tick(3);
    checks++;
    if (dut.ProgramCounter_0.pc !== 32'd12) begin
      fails++;
      $display("FAIL br_pc3 got %h want %h",
               dut.ProgramCounter_0.pc, 32'd12);
    end
    tick();
    checks++;
    if (dut.ProgramCounter_0.pc !== 32'd20) begin
      fails++;
      $display("FAIL br_target got %h want %h",
               dut.ProgramCounter_0.pc, 32'd20);
    end
    tick(6);
    checks++;
    if (dut.Registers_0.data[23] !== 32'd7 ||
        dut.Registers_0.data[24] !== 32'd8 ||
        dut.Registers_0.data[25] !== 32'd9) begin
      fails++;
      $display("FAIL br_slots got %h %h %h want 7 8 9",
               dut.Registers_0.data[23],
               dut.Registers_0.data[24],
               dut.Registers_0.data[25]);
    end
    checks++;
    if (dut.Registers_0.data[26] !== 32'd26) begin
      fails++;
      $display("FAIL br_skip got %h want %h",
               dut.Registers_0.data[26], 32'd26);
    end
    checks++;
    if (dut.Registers_0.data[27] !== 32'd6) begin
      fails++;
      $display("FAIL br_land got %h want %h",
               dut.Registers_0.data[27], 32'd6);
    end
    dut.InstructionMemory_0.data[0] = i_op(4, 1, 2, 4);
    boot();
    dut.InstructionMemory_0.data[0] = i_op(4, 1, 2, 4);
    dut.InstructionMemory_0.data[4] = i_op(8, 0, 26, 5);
    go();
    tick(4);
    checks++;
    if (dut.ProgramCounter_0.pc !== 32'd16) begin
      fails++;
      $display("FAIL nbr_pc got %h want %h",
               dut.ProgramCounter_0.pc, 32'd16);
    end
    tick(6);
    checks++;
    if (dut.Registers_0.data[26] !== 32'd5) begin
      fails++;
      $display("FAIL nbr_r26 got %h want %h",
               dut.Registers_0.data[26], 32'd5);
    end
  endtask

  task automatic test_hazard();
    boot();
    dut.InstructionMemory_0.data[0] = r_op(0, 1, 1, 'h20);
    dut.InstructionMemory_0.data[1] = r_op(22, 0, 1, 'h20);
    dut.InstructionMemory_0.data[2] = i_op(8, 0, 20, 100);
    dut.InstructionMemory_0.data[3] = r_op(21, 20, 0, 'h20);
    dut.InstructionMemory_0.data[5] = r_op(19, 20, 0, 'h20);
    go();
    tick(10);
    checks++;
    if (dut.Registers_0.data[0] !== 32'd0) begin
      fails++;
      $display("FAIL r0_write got %h want %h",
               dut.Registers_0.data[0], 32'd0);
    end
    checks++;
    if (dut.Registers_0.data[22] !== 32'd1) begin
      fails++;
      $display("FAIL r0_read got %h want %h",
               dut.Registers_0.data[22], 32'd1);
    end
    checks++;
    if (dut.Registers_0.data[21] !== 32'd20) begin
      fails++;
      $display("FAIL stale_r21 got %h want %h",
               dut.Registers_0.data[21], 32'd20);
    end
    checks++;
    if (dut.Registers_0.data[19] !== 32'd100) begin
      fails++;
      $display("FAIL bypass_r19 got %h want %h",
               dut.Registers_0.data[19], 32'd100);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    test_reset();
    test_program();
    test_load();
    test_alu();
    test_branch();
    test_hazard();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu.md
# cpu

Five-stage pipelined 32-bit MIPS-subset processor (IF, ID, EX, MEM, WB) for the lab-8 datapath. It is the top of the CPU design, with instruction memory, register file and data memory all inside it. It has no external bus: programs and data are preloaded by the bench through hierarchical access. There is no hazard detection and no forwarding; software inserts independent instructions or nops.

## Interface
- `INSTR_MEM_SIZE`, default 32: number of 32-bit words in instruction memory.
- `DATA_MEM_SIZE`, default 32: number of 32-bit words in data memory.
- `clock` input, 1 bit: single clock, all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.

## Operation
- Supported instructions:
  - R-type (opcode 0): `add` (funct 0x20), `sub` (0x22), `and` (0x24), `or` (0x25), `slt` (0x2A, signed).
  - `lw` (0x23), `sw` (0x2B), `beq` (0x04), `addi` (0x08).
- All-zero word is a nop. Any other opcode or funct decodes as a nop: no register write, no memory write.
- Arithmetic is 32-bit wrap-around with no overflow trap. Immediates are sign-extended.
- The branch target is PC+4 + (sext(imm) << 2).
- IF: instruction = `InstructionMemory_0.data[pc[31:2] mod INSTR_MEM_SIZE]`. PC+4 is latched into IF/ID.
- ID: combinational read of rs and rt, decode of control, sign-extend.
- EX: ALU operation; the destination is rd for R-type and rt for `lw`/`addi`; the branch target is computed.
- MEM: data memory word address = ALU result [31:2] mod DATA_MEM_SIZE.
  - `sw` writes rt data on the clock edge.
  - `lw` reads combinationally.
  - `beq` is resolved here (zero flag). If taken, the PC loads the target on this edge.
  - Instructions already in IF/ID/EX are not flushed: three branch delay slots.
- WB: writes ALU result or load data to the destination register. Writes to register 0 are ignored; register 0 always reads 0.
- Register file read bypass: a read of the register being written in the same cycle returns the new write data.
- Reset (while `reset` is high at a clock edge):
  - `ProgramCounter_0.pc` is set to 0.
  - All pipeline registers are cleared to nop (no write enables).
  - Register file and memories are not cleared.
  - Reset may be asserted mid-program; in-flight instructions are discarded with no further writes.
- Required instance names, used by benches:
  - `ProgramCounter_0` with reg `pc[31:0]`.
  - `InstructionMemory_0` with `data[0:INSTR_MEM_SIZE-1]`.
  - `Registers_0` with `data[0:31]`.
  - `DataMemory_0` with `data[0:DATA_MEM_SIZE-1]`.
  - Each array is 32-bit words and writable from the bench.

## Timing
- When not in reset, PC advances by 4 every edge (or loads the branch target). After N edges out of reset, pc = 4N with no taken branches.
- An instruction fetched at edge k has its register write visible after edge k+4. Its `sw` memory write lands at edge k+3.
- Result latency to a dependent consumer:
  - A consumer placed 3 or more instructions later reads the correct value.
  - Closer consumers read the stale value. This is defined behaviour and is not an error.
- Memory out-of-range addresses wrap modulo size. No stall cycles, ever.

## Structure
- Shared constants header/package: opcodes, funct codes, ALU-control encodings, nop word.
- Sub-modules:
  - `ProgramCounter`
  - `InstructionMemory`
  - `Registers` (2 read ports, 1 write port, with bypass)
  - `DataMemory`
  - `ALU`
  - `Control` (main decode plus ALU decode)
- Pipeline registers live in the top level.

## Test plan
Registers initialised to `data[i] = i`, then `reset` is high for one edge.
- Reset: hold `reset` high for 3 edges. Required: pc = 0 throughout, and no register or memory changes.
- Hazard-free program, run for 8 edges. Required after the 8th edge: $18 = 12, $9 = 1, data[16] = 12, pc = 32, and all other registers unchanged. Program:
  - `add $18,$4,$8`
  - `slt $9,$1,$2`
  - nop
  - `sw $18,64($0)`
  - nop
- Load: data[2] = 0x1234, run `lw $10,8($0)`. Required: $10 = 0x1234 after edge 5. Then `addi $11,$0,-1` gives $11 = 0xFFFFFFFF.
- `sub`/`and`/`or`: `sub $12,$3,$5` gives 0xFFFFFFFE; `and $13,$6,$3` gives 2; `or $14,$4,$1` gives 5.
- Taken branch: `beq $1,$1,+4` at pc 0. Required:
  - The three following instructions execute (delay slots).
  - The fetch after the MEM-stage edge is from address 20.
  - Untaken `beq $1,$2` causes sequential fetch.
- Register 0 and hazard: `add $0,$1,$1` leaves $0 = 0. An immediately dependent instruction reads the old value (stale read confirmed).
